// File: rtl/isqrt_sum_fsm.sv
// isqrt_sum_fsm: sums isqrt(x[i]) over N_ARGS arguments by time-multiplexing
// them over N_UNITS external isqrt units, round by round.
// Optional feature macro: ISQRT_SUM_SAT_EN (saturating accumulator when defined,
// modulo-2**RES_W accumulator otherwise).
// All outputs are registered; they are computed from the next-state values so
// they line up with the state they belong to.

module isqrt_sum_fsm #(
    parameter int N_ARGS  = 3,
    parameter int N_UNITS = 2,
    parameter int RES_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arg_vld,
    output logic                    arg_rdy,
    input  logic [N_ARGS*32-1:0]    args,
    output logic                    res_vld,
    output logic [RES_W-1:0]        res,
    output logic [N_UNITS-1:0]      isqrt_x_vld,
    output logic [N_UNITS*32-1:0]   isqrt_x,
    input  logic [N_UNITS-1:0]      isqrt_y_vld,
    input  logic [N_UNITS*16-1:0]   isqrt_y
);

    localparam int ROUNDS = (N_ARGS + N_UNITS - 1) / N_UNITS;
    localparam int RND_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
`ifdef ISQRT_SUM_SAT_EN
    // Wide enough for acc at its maximum plus one full root from every unit.
    localparam int SUM_W  = RES_W + $clog2(N_UNITS + 1);
    localparam logic [SUM_W-1:0] SAT_MAX = {{(SUM_W-RES_W){1'b0}}, {RES_W{1'b1}}};
`else
    localparam int SUM_W  = RES_W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [N_ARGS*32-1:0]   args_q, args_d;
    logic [RES_W-1:0]       acc_q, acc_d;
    logic [N_UNITS-1:0]     pending_q, pending_d;
    logic [RND_W-1:0]       round_q, round_d;
    logic [RES_W-1:0]       res_q, res_d;
    logic                   res_vld_q, res_vld_d;
    logic                   arg_rdy_q, arg_rdy_d;
    logic [N_UNITS-1:0]     x_vld_q, x_vld_d;
    logic [N_UNITS*32-1:0]  x_q, x_d;

    logic [N_UNITS-1:0]     hit_s;
    logic [SUM_W-1:0]       total_s;
    logic [RES_W-1:0]       acc_add_s;

    // Units whose argument index exists in the given round.
    function automatic logic [N_UNITS-1:0] active_mask(input logic [RND_W-1:0] rnd);
        logic [N_UNITS-1:0] m;
        m = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            m[u] = ((int'(rnd) * N_UNITS + u) < N_ARGS);
        end
        return m;
    endfunction

    // Argument that unit u works on in round rnd (zero when the unit is idle).
    function automatic logic [31:0] unit_arg(input logic [N_ARGS*32-1:0] vec,
                                             input logic [RND_W-1:0] rnd,
                                             input int u);
        logic [31:0] sel;
        int          idx;
        int          idx_c;
        sel = 32'd0;
        for (int r = 0; r < ROUNDS; r++) begin
            idx   = r * N_UNITS + u;
            idx_c = (idx < N_ARGS) ? idx : 0;
            if ((int'(rnd) == r) && (idx < N_ARGS)) begin
                sel = vec[32*idx_c +: 32];
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // Accumulator update: sum every accepted response this cycle onto acc.
    always_comb begin
        hit_s   = isqrt_y_vld & pending_q;
        total_s = SUM_W'(acc_q);
        for (int u = 0; u < N_UNITS; u++) begin
            if (hit_s[u]) begin
                total_s = total_s + SUM_W'(isqrt_y[16*u +: 16]);
            end else begin
                total_s = total_s;
            end
        end
`ifdef ISQRT_SUM_SAT_EN
        if (total_s > SAT_MAX) begin
            acc_add_s = {RES_W{1'b1}};
        end else begin
            acc_add_s = total_s[RES_W-1:0];
        end
`else
        acc_add_s = total_s;
`endif
    end

    // Next-state logic and registered-output precomputation.
    always_comb begin
        state_d   = state_q;
        args_d    = args_q;
        acc_d     = acc_q;
        pending_d = pending_q;
        round_d   = round_q;
        res_d     = res_q;
        res_vld_d = 1'b0;
        arg_rdy_d = 1'b0;
        x_vld_d   = '0;
        x_d       = x_q;

        case (state_q)
            ST_IDLE: begin
                if (arg_vld) begin
                    args_d  = args;
                    acc_d   = '0;
                    round_d = '0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                pending_d = active_mask(round_q);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                acc_d     = acc_add_s;
                pending_d = pending_q & ~hit_s;
                if (pending_d == '0) begin
                    if (round_q < RND_W'(ROUNDS - 1)) begin
                        round_d = round_q + RND_W'(1);
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_OUT;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        arg_rdy_d = (state_d == ST_IDLE);

        if (state_d == ST_ISSUE) begin
            x_vld_d = active_mask(round_d);
            for (int u = 0; u < N_UNITS; u++) begin
                x_d[32*u +: 32] = unit_arg(args_d, round_d, u);
            end
        end else begin
            x_vld_d = '0;
        end

        if (state_d == ST_OUT) begin
            res_vld_d = 1'b1;
            res_d     = acc_d;
        end else begin
            res_vld_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            args_q    <= '0;
            acc_q     <= '0;
            pending_q <= '0;
            round_q   <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            arg_rdy_q <= 1'b1;
            x_vld_q   <= '0;
            x_q       <= '0;
        end else begin
            state_q   <= state_d;
            args_q    <= args_d;
            acc_q     <= acc_d;
            pending_q <= pending_d;
            round_q   <= round_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            arg_rdy_q <= arg_rdy_d;
            x_vld_q   <= x_vld_d;
            x_q       <= x_d;
        end
    end

    assign arg_rdy     = arg_rdy_q;
    assign res_vld     = res_vld_q;
    assign res         = res_q;
    assign isqrt_x_vld = x_vld_q;
    assign isqrt_x     = x_q;

endmodule
